// File: rtl/uart_pkg.sv
// uart_pkg: shared state/parity types and bit helpers for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_e;
    typedef enum logic [1:0] {NONE, ODD, EVEN} parity_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // data is zero-extended by callers; extra zeros do not change the XOR
    function automatic logic calc_parity(input logic [8:0] data, input parity_e p);
        return p == EVEN ? ^data : p == ODD ? ~^data : 1'b0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with one-cycle first-word latency and combinational head read
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    // storage and pointers; a pop in the same cycle frees room for a push when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= wdata;
                wp              <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: configurable UART receiver with majority sampling, error/break detection and receive FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int      CYCLE = CLK_FREQ / BAUD_RATE;
    localparam int      CW    = $clog2(CYCLE);
    localparam int      HALF  = CYCLE / 2;
    localparam int      FW    = DATA_BITS + 2;
    localparam parity_e PMODE = parity_e'(PARITY);

    if (CYCLE < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    state_e               state;
    logic                 rx_m, rx_s, s0, s1, smp, mid, last;
    logic [CW-1:0]        cyc_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 perr, ferr, push_q, brk_q, full, empty, pop;
    logic [FW-1:0]        wdata_q, rdata;

    assign smp       = majority3(s0, s1, rx_s);
    assign mid       = cyc_cnt == CW'(HALF);
    assign last      = cyc_cnt == CW'(CYCLE - 1);
    assign busy      = state != IDLE;
    assign break_det = brk_q;
    assign m_valid   = ~empty;
    assign pop       = m_valid & m_ready;
    assign overrun   = push_q & full & ~pop;
    assign {m_parity_err, m_frame_err, m_data} = rdata;

    // two-flop synchroniser, idling high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // capture the two early samples; the third is rx_s itself at mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (cyc_cnt == CW'(HALF - 2)) s0 <= rx_s;
            if (cyc_cnt == CW'(HALF - 1)) s1 <= rx_s;
        end
    end

    // frame FSM; completion is taken at the last stop mid-sample to leave resync margin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            push_q  <= 1'b0;
            brk_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            push_q <= 1'b0;
            brk_q  <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state   <= START;
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    perr    <= 1'b0;
                    ferr    <= 1'b0;
                end
                START: if (mid && smp) begin
                    state   <= IDLE;
                    cyc_cnt <= '0;
                end else if (last) begin
                    state   <= DATA;
                    cyc_cnt <= '0;
                end else cyc_cnt <= cyc_cnt + 1'b1;
                DATA: begin
                    if (mid) shift <= {smp, shift[DATA_BITS-1:1]};
                    if (!last) cyc_cnt <= cyc_cnt + 1'b1;
                    else begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= PMODE != NONE ? uart_pkg::PARITY : STOP;
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (mid) perr <= smp != calc_parity(9'(shift), PMODE);
                    if (!last) cyc_cnt <= cyc_cnt + 1'b1;
                    else begin
                        cyc_cnt <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (mid && bit_cnt == 4'(STOP_BITS - 1)) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        if (shift == '0 && !smp) begin
                            state <= BRK;
                            brk_q <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            push_q  <= 1'b1;
                            wdata_q <= {perr, ferr | ~smp, shift};
                        end
                    end else begin
                        if (mid) ferr <= ferr | ~smp;
                        if (!last) cyc_cnt <= cyc_cnt + 1'b1;
                        else begin
                            cyc_cnt <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                BRK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push_q),
        .pop  (pop),
        .wdata(wdata_q),
        .rdata(rdata),
        .full (full),
        .empty(empty)
    );

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds configurable data bits, parity, stop bits, 3-sample majority voting, false-start rejection, framing/parity/break detection, and a receive FIFO with valid/ready output. It sits between the board rx pin and the CPU-side MMIO/loader logic, and runs in the single core clock domain.

Parameters:
CLK_FREQ, 100_000_000, core clock frequency in Hz
BAUD_RATE, 115_200, line rate; CYCLE = CLK_FREQ/BAUD_RATE (integer divide); compile-time error if CYCLE < 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal values 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and ≥ 2

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial input; idles high
m_data  out  DATA_BITS  FIFO head data (LSB = first bit received)
m_frame_err  out  1  FIFO head flag: stop bit sampled 0
m_parity_err  out  1  FIFO head flag: parity mismatch (always 0 when PARITY = 0)
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts the head when m_valid & m_ready
overrun  out  1  1-cycle pulse: frame completed while FIFO full; that frame is dropped
break_det  out  1  1-cycle pulse: break condition detected
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Every flop is cleared on rst_n low. Reset state:
  - Synchroniser flops = 1; state = IDLE; FIFO empty.
  - m_valid, overrun, break_det, busy = 0; m_data and flags = 0.
- rx passes through a 2-flop synchroniser; rx_s is the result. All logic below uses rx_s only.
- Bit timing:
  - cyc_cnt has width $clog2(CYCLE) and is cleared on every state change.
  - In bit states it wraps CYCLE-1 → 0 and increments bit_cnt.
  - Majority sample: rx_s is captured at cyc_cnt = CYCLE/2-2, CYCLE/2-1 and CYCLE/2. The bit value is majority3 of these, valid at the CYCLE/2 sample.
- States:
  - IDLE: rx_s == 0 → START.
  - START: at the CYCLE/2 sample, majority 1 → IDLE (false start, nothing pushed, no pulse). At cyc_cnt = CYCLE-1 → DATA.
  - DATA: store each sampled bit into shift[bit_cnt], LSB first. At cyc_cnt = CYCLE-1 with bit_cnt = DATA_BITS-1 → PARITY if PARITY != 0, else STOP.
  - PARITY: sample the bit. parity_err = (sample != expected), where expected = ^data for even parity and ~^data for odd. At cyc_cnt = CYCLE-1 → STOP.
  - STOP: sample each stop bit; frame_err if any sample is 0.
    - Mid-sample of the last stop bit, normal case: complete the frame and go straight to IDLE. Do not wait out the second half-bit; this gives resync margin.
    - Mid-sample of the last stop bit, data all zero and stop sample 0: this is a break. Pulse break_det, push nothing, go to BRK.
  - BRK: stay until rx_s == 1, then → IDLE.
- Frame completion:
  - If FIFO not full, push {parity_err, frame_err, data} on the completion cycle.
  - If FIFO full, pulse overrun on that cycle; FIFO contents are unchanged.
- FIFO:
  - Synchronous, first-word latency 1: m_valid rises the cycle after a push into an empty FIFO.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop when full: the pop frees an entry, so the push succeeds and no overrun is reported.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from MSB compare.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. After release the block waits for rx_s == 0 from IDLE.
- Latency: the last stop-bit mid-sample is followed by push (+1 cycle), then m_valid (+1 cycle). Total rx edge to m_valid is roughly 2 (sync) + frame time − CYCLE/2 + 2 cycles.

Decomposition:
- Package uart_pkg holds:
  - state_e enum: IDLE, START, DATA, PARITY, STOP, BRK
  - parity_e enum: NONE, ODD, EVEN
  - function majority3
  - function calc_parity(data, parity_e)
- One sub-module, sync_fifo (WIDTH, DEPTH), with push/pop/full/empty. It is reused later by the transmit path.

Test Plan:
Benches use CLK_FREQ = 1_600_000 and BAUD_RATE = 100_000, giving CYCLE = 16.
1. 8N1: send 0xA5 → m_data = 0xA5, both error flags 0, m_valid exactly 2 cycles after the stop mid-sample; holds until m_ready.
2. PARITY = 2 (even), send 0x03 with parity bit 1 (wrong) → m_data = 0x03, m_parity_err = 1. Resend with parity 0 → m_parity_err = 0.
3. Glitch: rx low for 5 cycles, then high → no push, busy drops within 1 cycle of the START mid-sample, state back in IDLE.
4. Send 0x55 with stop bit 0 → m_data = 0x55, m_frame_err = 1. The next good frame 0x3C is received cleanly.
5. FIFO_DEPTH = 4, m_ready = 0, send 0x11, 0x22, 0x33, 0x44, 0x55 → one overrun pulse on the 5th frame. Draining yields 0x11..0x44 in order, then m_valid = 0.
6. Hold rx low for 20 bit-times → one break_det pulse, no push, busy high until rx returns high. Separately, assert rst_n low mid-DATA → m_valid = 0 and busy = 0 immediately, and a following 0x7E is received correctly.
